// File: rtl/z80_io_hub_if.sv
// Z80 I/O bus strobes and decoded address bits, CPU side to hub.
interface z80_io_hub_if #(
   parameter int ADR_W = 3
);
   logic [ADR_W-1:0] adr;
   logic             rd;
   logic             wr;
   logic             iorq;
   logic             m1;

   modport master (output adr, rd, wr, iorq, m1);
   modport slave  (input  adr, rd, wr, iorq, m1);
endinterface

// File: rtl/z80_io_hub.sv
// Z80 I/O glue: CPU clock divider with speed select, output registers,
// timed LCD1602 write engine and open-drain keyboard row strobe.
module z80_io_hub #(
   parameter int ADR_W    = 3,
   parameter int NREG     = 4,
   parameter int REG_BASE = 0,
   parameter int LCD_ADR  = 5,
   parameter int KBD_ADR  = 6,
   parameter int DIV_W    = 5,
   parameter int DIV_FAST = 1,
   parameter int DIV_SLOW = 3,
   parameter int LCD_SU   = 2,
   parameter int LCD_EW   = 12,
   parameter int LCD_HLD  = 4
) (
   input  logic                  in_clock,
   input  logic                  rst,
   z80_io_hub_if.slave           bus,
   inout  wire  [7:0]            data,
   output logic                  cpu_clock,
   output logic                  led,
   output logic                  lcd_e,
   output logic                  lcd_rw,
   output logic                  lcd_rs,
   output logic [7:0]            lcd_d,
   output logic [8*(NREG-1)-1:0] reg_out,
   output wire                   kbd
);

   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [7:0] SU_N  = 8'(LCD_SU - 1);
   localparam logic [7:0] EW_N  = 8'(LCD_EW - 1);
   localparam logic [7:0] HLD_N = 8'(LCD_HLD - 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_st_t;

   logic [ADR_W-1:0] adr;
   logic [7:0]       regs [NREG];
   logic [7:0]       ctrl;
   logic [DIV_W-1:0] div;
   logic             speed_act;
   logic [3:0]       sy1, sy2;
   logic             iowr_s, iord_s, iowr_q, iord_q;
   logic             wr_ev, rd_ev;
   logic             hit_reg, hit_lcd, hit_kbd;
   logic [IW-1:0]    idx;
   logic             rd_act, rd_oe, kbd_rd;
   logic [7:0]       rd_val;
   lcd_st_t          st, st_n;
   logic [7:0]       cnt, cnt_n;
   logic             busy, overrun, lcd_wr;

   assign adr  = bus.adr;
   assign ctrl = regs[0];

   // Address windows are masked so that at most one decode is ever live.
   assign hit_reg = (int'(adr) >= REG_BASE) &&
                    (int'(adr) < REG_BASE + NREG);
   assign hit_lcd = !hit_reg && (int'(adr) == LCD_ADR);
   assign hit_kbd = !hit_reg && !hit_lcd && (int'(adr) == KBD_ADR);
   assign idx     = IW'(int'(adr) - REG_BASE);

   always_ff @(posedge in_clock or negedge rst) begin
      if (!rst) begin
         div       <= '0;
         speed_act <= 1'b0;
      end else begin
         div <= div + 1'b1;
         if (div[DIV_SLOW:0] == '0)
            speed_act <= ctrl[3];
      end
   end

   assign cpu_clock = speed_act ? div[DIV_SLOW] : div[DIV_FAST];

   always_ff @(posedge in_clock or negedge rst) begin
      if (!rst) begin
         sy1    <= '1;
         sy2    <= '1;
         iowr_q <= 1'b0;
         iord_q <= 1'b0;
      end else begin
         sy1    <= {bus.iorq, bus.wr, bus.rd, bus.m1};
         sy2    <= sy1;
         iowr_q <= iowr_s;
         iord_q <= iord_s;
      end
   end

   // INTA drives iorq and m1 low together; m1 high keeps it out.
   assign iowr_s = !sy2[3] && !sy2[2] && sy2[0];
   assign iord_s = !sy2[3] && !sy2[1] && sy2[0];
   assign wr_ev  = iowr_s && !iowr_q;
   assign rd_ev  = iord_s && !iord_q;
   assign lcd_wr = wr_ev && hit_lcd;

   always_ff @(posedge in_clock or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_ev && hit_reg) begin
         regs[idx] <= data;
      end
   end

   for (genvar k = 1; k < NREG; k++) begin : g_out
      assign reg_out[8*k-1 -: 8] = regs[k];
   end

   assign led    = ctrl[0];
   assign lcd_rw = ctrl[1];
   assign lcd_rs = ctrl[2];

   always_ff @(posedge in_clock or negedge rst) begin
      if (!rst) begin
         st  <= IDLE;
         cnt <= '0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
      end
   end

   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      unique case (st)
         IDLE:
            if (lcd_wr) begin
               st_n  = SETUP;
               cnt_n = SU_N;
            end
         SETUP:
            if (cnt == '0) begin
               st_n  = PULSE;
               cnt_n = EW_N;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         PULSE:
            if (cnt == '0) begin
               st_n  = HOLD;
               cnt_n = HLD_N;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         HOLD:
            if (cnt == '0) st_n = IDLE;
            else           cnt_n = cnt - 1'b1;
         default: st_n = IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      lcd_e = 1'b0;
      unique case (st)
         IDLE:    busy = 1'b0;
         SETUP:   busy = 1'b1;
         PULSE: begin
            busy  = 1'b1;
            lcd_e = 1'b1;
         end
         HOLD:    busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // A dropped write in the same cycle as a status read keeps overrun set.
   always_ff @(posedge in_clock or negedge rst) begin
      if (!rst) begin
         lcd_d   <= '0;
         overrun <= 1'b0;
      end else begin
         if (lcd_wr && st == IDLE)
            lcd_d <= data;
         if (lcd_wr && st != IDLE)
            overrun <= 1'b1;
         else if (rd_ev && hit_lcd)
            overrun <= 1'b0;
      end
   end

   assign rd_act = !bus.iorq && !bus.rd && bus.m1;

   always_comb begin
      rd_oe  = 1'b0;
      rd_val = '0;
      kbd_rd = 1'b0;
      unique case (1'b1)
         rd_act && hit_reg: begin
            rd_oe  = 1'b1;
            rd_val = regs[idx];
         end
         rd_act && hit_lcd: begin
            rd_oe  = 1'b1;
            rd_val = {6'b0, overrun, busy};
         end
         rd_act && hit_kbd: kbd_rd = 1'b1;
         default: ;
      endcase
   end

   assign data = rd_oe ? rd_val : 8'hzz;
   assign kbd  = kbd_rd ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_z80_io_hub.sv
// Directed bench for z80_io_hub: divider, registers, LCD engine,
// status/overrun, INTA gating, keyboard strobe and async reset.
module tb_z80_io_hub;

   logic        in_clock = 1'b0;
   logic        rst      = 1'b0;
   logic        d_oe     = 1'b0;
   logic [7:0]  d_drv    = '0;
   wire  [7:0]  data;
   wire         kbd;
   logic        cpu_clock, led, lcd_e, lcd_rw, lcd_rs;
   logic [7:0]  lcd_d;
   logic [23:0] reg_out;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int d_first, e_first, e_cnt, t0;
   int min_run, per;
   logic [7:0] rv;
   logic       rk;

   z80_io_hub_if #(.ADR_W(3)) bus ();

   assign data = d_oe ? d_drv : 8'hzz;
   pullup (data);
   pullup (kbd);

   z80_io_hub dut (
      .in_clock  (in_clock),
      .rst       (rst),
      .bus       (bus),
      .data      (data),
      .cpu_clock (cpu_clock),
      .led       (led),
      .lcd_e     (lcd_e),
      .lcd_rw    (lcd_rw),
      .lcd_rs    (lcd_rs),
      .lcd_d     (lcd_d),
      .reg_out   (reg_out),
      .kbd       (kbd)
   );

   always #5 in_clock = ~in_clock;
   always @(posedge in_clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic io_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge in_clock);
      bus.adr  = a;
      d_drv    = d;
      d_oe     = 1'b1;
      bus.iorq = 1'b0;
      bus.wr   = 1'b0;
      repeat (5) @(negedge in_clock);
      bus.iorq = 1'b1;
      bus.wr   = 1'b1;
      @(negedge in_clock);
      d_oe = 1'b0;
   endtask

   task automatic io_rd(input logic [2:0] a, output logic [7:0] d,
                        output logic k);
      @(negedge in_clock);
      bus.adr  = a;
      bus.iorq = 1'b0;
      bus.rd   = 1'b0;
      #1;
      d = data;
      k = kbd;
      repeat (4) @(negedge in_clock);
      bus.iorq = 1'b1;
      bus.rd   = 1'b1;
      repeat (3) @(negedge in_clock);
   endtask

   task automatic clk_scan(input int n, output int mr, output int pr);
      logic prev;
      int   run, last_rise;
      bit   first;
      mr = 1000; pr = 0; last_rise = -1; first = 1'b1;
      @(negedge in_clock);
      prev = cpu_clock;
      run  = 1;
      for (int i = 1; i < n; i++) begin
         @(negedge in_clock);
         if (cpu_clock == prev) begin
            run++;
         end else begin
            if (!first && run < mr) mr = run;
            first = 1'b0;
            if (cpu_clock) begin
               if (last_rise >= 0) pr = i - last_rise;
               last_rise = i;
            end
            prev = cpu_clock;
            run  = 1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.adr = '0; bus.rd = 1'b1; bus.wr = 1'b1;
      bus.iorq = 1'b1; bus.m1 = 1'b1;
      repeat (3) @(negedge in_clock);
      check("rst_cpuclk", cpu_clock, 0);
      check("rst_lcd_e", lcd_e, 0);
      check("rst_lcd_d", lcd_d, 0);
      check("rst_regs", reg_out, 0);
      check("rst_ctl", {led, lcd_rw, lcd_rs}, 0);
      check("rst_data_z", data, 8'hff);
      check("rst_kbd_z", kbd, 1);
      rst = 1'b1;

      clk_scan(32, min_run, per);
      check("fast_per", per, 4);
      check("fast_run", min_run, 2);

      fork
         io_wr(0, 8'h08);
         clk_scan(60, min_run, per);
      join
      check("slow_per", per, 16);
      check("slow_norunt", min_run >= 2, 1);
      check("slow_led", led, 0);

      fork
         io_wr(0, 8'h00);
         clk_scan(60, min_run, per);
      join
      check("back_per", per, 4);
      check("back_norunt", min_run >= 2, 1);

      io_wr(1, 8'hA5);
      io_wr(3, 8'h3C);
      check("reg1", reg_out[7:0], 8'hA5);
      check("reg2", reg_out[15:8], 8'h00);
      check("reg3", reg_out[23:16], 8'h3C);
      io_rd(1, rv, rk);
      check("in1", rv, 8'hA5);
      check("in1_kbd", rk, 1);
      io_rd(3, rv, rk);
      check("in3", rv, 8'h3C);
      io_rd(7, rv, rk);
      check("in7_z", rv, 8'hff);

      io_wr(0, 8'h07);
      check("ctl_pins", {led, lcd_rw, lcd_rs}, 3'b111);
      io_rd(0, rv, rk);
      check("in0", rv, 8'h07);
      io_wr(0, 8'h00);
      check("ctl_clr", {led, lcd_rw, lcd_rs}, 3'b000);

      d_first = -1; e_first = -1; e_cnt = 0;
      fork
         begin
            io_wr(5, 8'h41);
            t0 = (d_first < 0) ? cyc : d_first;
            while (cyc < t0 + 17) @(negedge in_clock);
            bus.adr = 5; bus.iorq = 1'b0; bus.rd = 1'b0;
            #1 check("st_busy", data, 8'h01);
            @(negedge in_clock);
            #1 check("st_done", data, 8'h00);
            bus.iorq = 1'b1; bus.rd = 1'b1;
         end
         begin
            for (int i = 0; i < 28; i++) begin
               @(negedge in_clock);
               if (d_first < 0 && lcd_d == 8'h41) d_first = cyc;
               if (lcd_e) begin
                  if (e_first < 0) e_first = cyc;
                  e_cnt++;
               end
            end
         end
      join
      repeat (4) @(negedge in_clock);
      check("lcd_d", lcd_d, 8'h41);
      check("e_delay", e_first - d_first, 2);
      check("e_width", e_cnt, 12);

      io_wr(5, 8'h55);
      io_wr(5, 8'h99);
      check("ovr_keep_d", lcd_d, 8'h55);
      io_rd(5, rv, rk);
      check("ovr_status", rv, 8'h03);
      repeat (20) @(negedge in_clock);
      io_rd(5, rv, rk);
      check("ovr_clear", rv, 8'h00);

      @(negedge in_clock);
      bus.adr = 5; bus.iorq = 1'b0; bus.m1 = 1'b0; bus.rd = 1'b0;
      #1 check("inta_data_z", data, 8'hff);
      bus.adr = 6;
      #1 check("inta_kbd_z", kbd, 1);
      bus.rd = 1'b1; bus.adr = 5;
      d_drv = 8'h77; d_oe = 1'b1; bus.wr = 1'b0;
      repeat (6) @(negedge in_clock);
      bus.wr = 1'b1; bus.iorq = 1'b1; bus.m1 = 1'b1;
      @(negedge in_clock);
      d_oe = 1'b0;
      repeat (4) @(negedge in_clock);
      check("inta_no_lcd", lcd_d, 8'h55);
      io_rd(5, rv, rk);
      check("inta_status", rv, 8'h00);
      io_rd(6, rv, rk);
      check("kbd_strobe", rk, 0);
      check("kbd_data_z", rv, 8'hff);

      io_wr(0, 8'h09);
      clk_scan(40, min_run, per);
      check("pre_rst_slow", per, 16);
      io_wr(5, 8'h42);
      check("e_before_rst", lcd_e, 1);
      rst = 1'b0;
      #1;
      check("rst_e_drop", lcd_e, 0);
      check("rst_regs2", reg_out, 0);
      check("rst_lcd_d2", lcd_d, 0);
      check("rst_led2", led, 0);
      check("rst_cpuclk2", cpu_clock, 0);
      repeat (2) @(negedge in_clock);
      rst = 1'b1;
      clk_scan(32, min_run, per);
      check("rst_fast_per", per, 4);
      io_rd(5, rv, rk);
      check("rst_status", rv, 8'h00);
      io_rd(0, rv, rk);
      check("rst_ctrl", rv, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
